// File: rtl/alu_elem_seq.sv
// Vector-lane ALU element sequencer: accepts one instruction, issues one element per cycle,
// and tracks in-flight elements through a latency shift register to drive VRF writeback.
module alu_elem_seq #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_VL     = 32,
  parameter int SHORT_LAT  = 1,
  parameter int LONG_LAT   = 3,
  localparam int IDX_W     = $clog2(MAX_VL),
  localparam int VL_W      = IDX_W + 1
) (
  input  logic             clk_i,
  input  logic             resetn_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [6:0]       req_ocode_i,
  input  logic             req_long_i,
  input  logic [VL_W-1:0]  req_vl_i,
  input  logic             req_vm_i,
  input  logic [MAX_VL-1:0] mask_i,
  input  logic             abort_i,
  output logic             alu_valid_o,
  output logic [6:0]       alu_ocode_o,
  output logic             alu_mask_e_o,
  output logic [IDX_W-1:0] elem_idx_o,
  output logic             wb_valid_o,
  output logic             wb_we_o,
  output logic [IDX_W-1:0] wb_idx_o,
  output logic             done_o,
  output logic [1:0]       dbg_state_o
);

  localparam int SLOT_W = (LONG_LAT > 1) ? $clog2(LONG_LAT) : 1;

  if (MAX_VL < 2 || (MAX_VL & (MAX_VL - 1)) != 0 || SHORT_LAT < 1 ||
      LONG_LAT <= SHORT_LAT || DATA_WIDTH < 1) begin : g_param_err
    $error("alu_elem_seq: invalid parameter set");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_ZWAIT = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [6:0]          ocode_q, ocode_d;
  logic                long_q, long_d;
  logic [VL_W-1:0]     vl_q, vl_d;
  logic                vm_q, vm_d;
  logic [MAX_VL-1:0]   mask_q, mask_d;
  logic [IDX_W-1:0]    cnt_q, cnt_d;
  logic [LONG_LAT-1:0] pv_q, pv_d, pwe_q, pwe_d, plast_q, plast_d;
  logic [IDX_W-1:0]    pidx_q [LONG_LAT];
  logic [IDX_W-1:0]    pidx_d [LONG_LAT];

  logic              hazard, last_elem, issue, ready, accept, zdone, pipe_empty;
  logic [SLOT_W-1:0] ent;

  // Request handshake: a request transfers on a rising edge where req_valid_i and
  // req_ready_o are both high; ready never depends on req_valid_i.
  always_comb begin
    hazard = 1'b0;
    for (int j = 0; j < LONG_LAT; j++) begin
      if (pv_q[j] && (j >= (long_q ? LONG_LAT : SHORT_LAT))) hazard = 1'b1;
    end
    ent        = long_q ? SLOT_W'(LONG_LAT - 1) : SLOT_W'(SHORT_LAT - 1);
    last_elem  = ({1'b0, cnt_q} == (vl_q - VL_W'(1)));
    pipe_empty = ~|pv_q;
    // Only element 0 checks the hazard; later elements share its latency.
    issue      = (state_q == S_ISSUE) && !abort_i && ((cnt_q != '0) || !hazard);
    ready      = !abort_i && ((state_q == S_IDLE) || (issue && last_elem));
    accept     = req_valid_i && ready;
    zdone      = (state_q == S_ZWAIT) && pipe_empty && !abort_i;
  end

  always_comb begin
    state_d = state_q;
    ocode_d = ocode_q;
    long_d  = long_q;
    vl_d    = vl_q;
    vm_d    = vm_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    if (issue && !last_elem) cnt_d = cnt_q + IDX_W'(1);
    unique case (state_q)
      S_IDLE:  ;
      S_ISSUE: if (abort_i) state_d = S_IDLE;
               else if (issue && last_elem) state_d = S_IDLE;
      S_ZWAIT: if (abort_i || pipe_empty) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (accept) begin
      ocode_d = req_ocode_i;
      long_d  = req_long_i;
      vl_d    = req_vl_i;
      vm_d    = req_vm_i;
      mask_d  = mask_i;
      cnt_d   = '0;
      state_d = (req_vl_i != '0) ? S_ISSUE : S_ZWAIT;
    end
  end

  // Slot 0 is the exit slot; an issue of latency L enters at slot L-1.
  always_comb begin
    pv_d    = pv_q >> 1;
    pwe_d   = pwe_q >> 1;
    plast_d = plast_q >> 1;
    for (int j = 0; j < LONG_LAT - 1; j++) pidx_d[j] = pidx_q[j+1];
    pidx_d[LONG_LAT-1] = '0;
    if (abort_i) pv_d = '0;
    if (issue) begin
      pv_d[ent]    = 1'b1;
      pwe_d[ent]   = vm_q | mask_q[cnt_q];
      plast_d[ent] = last_elem;
      pidx_d[ent]  = cnt_q;
    end
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q <= S_IDLE;
      ocode_q <= '0;
      long_q  <= 1'b0;
      vl_q    <= '0;
      vm_q    <= 1'b0;
      mask_q  <= '0;
      cnt_q   <= '0;
      pv_q    <= '0;
      pwe_q   <= '0;
      plast_q <= '0;
      for (int j = 0; j < LONG_LAT; j++) pidx_q[j] <= '0;
    end else begin
      state_q <= state_d;
      ocode_q <= ocode_d;
      long_q  <= long_d;
      vl_q    <= vl_d;
      vm_q    <= vm_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      pv_q    <= pv_d;
      pwe_q   <= pwe_d;
      plast_q <= plast_d;
      for (int j = 0; j < LONG_LAT; j++) pidx_q[j] <= pidx_d[j];
    end
  end

  assign req_ready_o  = ready;
  assign alu_valid_o  = issue;
  assign alu_ocode_o  = ocode_q;
  assign alu_mask_e_o = mask_q[cnt_q];
  assign elem_idx_o   = cnt_q;
  assign wb_valid_o   = pv_q[0];
  assign wb_we_o      = pv_q[0] & pwe_q[0];
  assign wb_idx_o     = pidx_q[0];
  assign done_o       = (pv_q[0] & plast_q[0]) | zdone;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_alu_elem_seq.sv
// Bench for alu_elem_seq: table-driven single-instruction vectors plus hand-written
// multi-cycle sequences (back-to-back, vl=0 drain, abort, full-length, async reset).
module tb_alu_elem_seq;
  localparam int MAX_VL = 32;
  localparam int IDX_W  = 5;
  localparam int VL_W   = 6;

  logic              clk_i, resetn_i;
  logic              req_valid_i, req_ready_o, req_long_i, req_vm_i, abort_i;
  logic [6:0]        req_ocode_i, alu_ocode_o;
  logic [VL_W-1:0]   req_vl_i;
  logic [MAX_VL-1:0] mask_i;
  logic              alu_valid_o, alu_mask_e_o, wb_valid_o, wb_we_o, done_o;
  logic [IDX_W-1:0]  elem_idx_o, wb_idx_o;
  logic [1:0]        dbg_state_o;

  alu_elem_seq #(.DATA_WIDTH(32), .MAX_VL(MAX_VL), .SHORT_LAT(1), .LONG_LAT(3)) dut (
    .clk_i(clk_i), .resetn_i(resetn_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_ocode_i(req_ocode_i), .req_long_i(req_long_i), .req_vl_i(req_vl_i), .req_vm_i(req_vm_i),
    .mask_i(mask_i), .abort_i(abort_i), .alu_valid_o(alu_valid_o), .alu_ocode_o(alu_ocode_o),
    .alu_mask_e_o(alu_mask_e_o), .elem_idx_o(elem_idx_o), .wb_valid_o(wb_valid_o),
    .wb_we_o(wb_we_o), .wb_idx_o(wb_idx_o), .done_o(done_o), .dbg_state_o(dbg_state_o)
  );

  // clock / reset
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  int checks = 0;
  int passes = 0;

  logic [63:0] alu_bits, wb_bits, done_bits, rdy_bits;
  logic [15:0] alu_obs_q[$], alu_exp_q[$];
  logic [7:0]  wb_obs_q[$], wb_exp_q[$];

  bit          sec_en;
  logic [6:0]  sec_ocode;
  logic        sec_long, sec_vm;
  logic [VL_W-1:0] sec_vl;
  logic [31:0] sec_mask;
  int          abort_cyc;

  typedef struct {
    logic [6:0]  ocode;
    logic        lng;
    int          vl;
    logic        vm;
    logic [31:0] mask;
    logic [31:0] exp_we;
    int          exp_lat;
    int          exp_done;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_ready"}, 64'(req_ready_o), 64'd1);
    chk({tag, "_alu_valid"}, 64'(alu_valid_o), 64'd0);
    chk({tag, "_wb_valid"}, 64'(wb_valid_o), 64'd0);
    chk({tag, "_wb_we"}, 64'(wb_we_o), 64'd0);
    chk({tag, "_done"}, 64'(done_o), 64'd0);
    chk({tag, "_elem_idx"}, 64'(elem_idx_o), 64'd0);
    chk({tag, "_wb_idx"}, 64'(wb_idx_o), 64'd0);
    chk({tag, "_ocode"}, 64'(alu_ocode_o), 64'd0);
  endtask

  task automatic drive_req(input logic [6:0] oc, input logic lng, input int vl,
                           input logic vm, input logic [31:0] m);
    req_ocode_i = oc;
    req_long_i  = lng;
    req_vl_i    = VL_W'(vl);
    req_vm_i    = vm;
    mask_i      = m;
    req_valid_i = 1'b1;
  endtask

  // driver: cycle 0 is the accept edge of the request already on the bus
  task automatic run_window(input int ncyc);
    bit drop;
    drop = 1'b0;
    alu_bits = '0; wb_bits = '0; done_bits = '0; rdy_bits = '0;
    alu_obs_q.delete();
    wb_obs_q.delete();
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk_i);
      if (c == 1) begin
        if (sec_en) drive_req(sec_ocode, sec_long, int'(sec_vl), sec_vm, sec_mask);
        else req_valid_i = 1'b0;
      end
      if (drop) begin
        req_valid_i = 1'b0;
        drop = 1'b0;
      end
      abort_i = (c == abort_cyc);
      #1;
      if (alu_valid_o) begin
        alu_bits[c] = 1'b1;
        alu_obs_q.push_back({2'b00, alu_ocode_o, alu_mask_e_o, elem_idx_o});
      end
      if (wb_valid_o) begin
        wb_bits[c] = 1'b1;
        wb_obs_q.push_back({2'b00, wb_we_o, wb_idx_o});
      end
      done_bits[c] = done_o;
      rdy_bits[c]  = req_ready_o;
      if (req_valid_i && req_ready_o) drop = 1'b1;
    end
    req_valid_i = 1'b0;
    abort_i     = 1'b0;
  endtask

  // scoreboard: compare observed events against expected queues
  task automatic cmp_queues(input string tag);
    chk({tag, "_alu_count"}, 64'(alu_obs_q.size()), 64'(alu_exp_q.size()));
    for (int i = 0; i < alu_exp_q.size() && i < alu_obs_q.size(); i++)
      chk($sformatf("%s_alu_ev%0d", tag, i), 64'(alu_obs_q[i]), 64'(alu_exp_q[i]));
    chk({tag, "_wb_count"}, 64'(wb_obs_q.size()), 64'(wb_exp_q.size()));
    for (int i = 0; i < wb_exp_q.size() && i < wb_obs_q.size(); i++)
      chk($sformatf("%s_wb_ev%0d", tag, i), 64'(wb_obs_q[i]), 64'(wb_exp_q[i]));
    alu_exp_q.delete();
    wb_exp_q.delete();
  endtask

  initial begin
    // ocode, long, vl, vm, mask, exp_we, exp_lat, exp_done
    vecs[0] = '{7'h01, 1'b0, 4, 1'b1, 32'h0, 32'hF,  1, 5};
    vecs[1] = '{7'h22, 1'b1, 3, 1'b0, 32'h5, 32'h5,  3, 6};
    vecs[2] = '{7'h03, 1'b0, 1, 1'b0, 32'h0, 32'h0,  1, 2};
    vecs[3] = '{7'h25, 1'b1, 5, 1'b1, 32'h0, 32'h1F, 3, 8};
    vecs[4] = '{7'h07, 1'b0, 3, 1'b0, 32'h6, 32'h6,  1, 4};
    vecs[5] = '{7'h09, 1'b0, 0, 1'b1, 32'h0, 32'h0,  1, 1};

    resetn_i = 1'b0; req_valid_i = 1'b0; req_ocode_i = '0; req_long_i = 1'b0;
    req_vl_i = '0; req_vm_i = 1'b0; mask_i = '0; abort_i = 1'b0;
    sec_en = 1'b0; abort_cyc = -1;
    sec_ocode = '0; sec_long = 1'b0; sec_vl = '0; sec_vm = 1'b0; sec_mask = '0;
    repeat (2) @(negedge clk_i);
    chk_idle_outputs("reset");
    resetn_i = 1'b1;
    @(negedge clk_i);
    chk_idle_outputs("post_reset");

    // table-driven single instructions from an idle, empty pipeline
    foreach (vecs[k]) begin
      @(negedge clk_i);
      drive_req(vecs[k].ocode, vecs[k].lng, vecs[k].vl, vecs[k].vm, vecs[k].mask);
      #1 chk($sformatf("v%0d_ready_at_accept", k), 64'(req_ready_o), 64'd1);
      sec_en = 1'b0; abort_cyc = -1;
      run_window(vecs[k].exp_done + 2);
      begin
        logic [63:0] ea, ew, ed;
        ea = '0; ew = '0; ed = '0;
        for (int i = 0; i < vecs[k].vl; i++) begin
          ea[i+1] = 1'b1;
          ew[vecs[k].exp_lat + 1 + i] = 1'b1;
          alu_exp_q.push_back({2'b00, vecs[k].ocode, vecs[k].mask[i], IDX_W'(i)});
          wb_exp_q.push_back({2'b00, vecs[k].exp_we[i], IDX_W'(i)});
        end
        ed[vecs[k].exp_done] = 1'b1;
        chk($sformatf("v%0d_alu_cycles", k), alu_bits, ea);
        chk($sformatf("v%0d_wb_cycles", k), wb_bits, ew);
        chk($sformatf("v%0d_done_cycles", k), done_bits, ed);
      end
      cmp_queues($sformatf("v%0d", k));
    end

    // long vl=2 then short vl=2: short element 0 stalls until long entries drain
    @(negedge clk_i);
    drive_req(7'h21, 1'b1, 2, 1'b1, 32'h0);
    sec_en = 1'b1; sec_ocode = 7'h02; sec_long = 1'b0; sec_vl = 6'd2; sec_vm = 1'b1; sec_mask = 32'h0;
    run_window(10);
    sec_en = 1'b0;
    alu_exp_q = '{{2'b00, 7'h21, 1'b0, 5'd0}, {2'b00, 7'h21, 1'b0, 5'd1},
                  {2'b00, 7'h02, 1'b0, 5'd0}, {2'b00, 7'h02, 1'b0, 5'd1}};
    wb_exp_q  = '{{2'b00, 1'b1, 5'd0}, {2'b00, 1'b1, 5'd1}, {2'b00, 1'b1, 5'd0}, {2'b00, 1'b1, 5'd1}};
    chk("ls_alu_cycles", alu_bits, 64'h66);
    chk("ls_wb_cycles", wb_bits, 64'hF0);
    chk("ls_done_cycles", done_bits, 64'hA0);
    chk("ls_ready_cycles", rdy_bits, 64'h7C4);
    cmp_queues("ls");

    // vl=0 accepted while a long instruction drains
    @(negedge clk_i);
    drive_req(7'h30, 1'b1, 3, 1'b0, 32'h2);
    sec_en = 1'b1; sec_ocode = 7'h31; sec_long = 1'b0; sec_vl = 6'd0; sec_vm = 1'b1; sec_mask = 32'h0;
    run_window(10);
    sec_en = 1'b0;
    alu_exp_q = '{{2'b00, 7'h30, 1'b0, 5'd0}, {2'b00, 7'h30, 1'b1, 5'd1}, {2'b00, 7'h30, 1'b0, 5'd2}};
    wb_exp_q  = '{{2'b00, 1'b0, 5'd0}, {2'b00, 1'b1, 5'd1}, {2'b00, 1'b0, 5'd2}};
    chk("z_alu_cycles", alu_bits, 64'hE);
    chk("z_wb_cycles", wb_bits, 64'h70);
    chk("z_done_cycles", done_bits, 64'hC0);
    chk("z_ready_cycles", rdy_bits, 64'h708);
    cmp_queues("z");

    // abort during issue of element 2 of a vl=8 instruction
    @(negedge clk_i);
    drive_req(7'h11, 1'b0, 8, 1'b1, 32'hFF);
    abort_cyc = 3;
    run_window(8);
    abort_cyc = -1;
    alu_exp_q = '{{2'b00, 7'h11, 1'b1, 5'd0}, {2'b00, 7'h11, 1'b1, 5'd1}};
    wb_exp_q  = '{{2'b00, 1'b1, 5'd0}, {2'b00, 1'b1, 5'd1}};
    chk("ab_alu_cycles", alu_bits, 64'h6);
    chk("ab_wb_cycles", wb_bits, 64'hC);
    chk("ab_done_cycles", done_bits, 64'h0);
    chk("ab_ready_cycles", rdy_bits, 64'h1F0);
    cmp_queues("ab");

    // full-length vl=MAX_VL, masked short op
    @(negedge clk_i);
    drive_req(7'h0A, 1'b0, 32, 1'b0, 32'hA5A5_0F0F);
    run_window(35);
    for (int i = 0; i < 32; i++) begin
      logic [31:0] m;
      m = 32'hA5A5_0F0F;
      alu_exp_q.push_back({2'b00, 7'h0A, m[i], IDX_W'(i)});
      wb_exp_q.push_back({2'b00, m[i], IDX_W'(i)});
    end
    chk("full_alu_cycles", alu_bits, 64'h1_FFFF_FFFE);
    chk("full_wb_cycles", wb_bits, 64'h3_FFFF_FFFC);
    chk("full_done_cycles", done_bits, 64'h2_0000_0000);
    chk("full_ready_cycles", rdy_bits, 64'hF_0000_0000);
    cmp_queues("full");

    // asynchronous reset in the middle of a full-length run
    @(negedge clk_i);
    drive_req(7'h0B, 1'b0, 32, 1'b1, 32'h0);
    @(negedge clk_i);
    req_valid_i = 1'b0;
    repeat (9) @(negedge clk_i);
    #1 chk("mid_alu_valid_before_reset", 64'(alu_valid_o), 64'd1);
    #1 resetn_i = 1'b0;
    #1 chk_idle_outputs("async_reset");
    @(negedge clk_i);
    resetn_i = 1'b1;
    run_window(5);
    chk("after_reset_alu_cycles", alu_bits, 64'h0);
    chk("after_reset_wb_cycles", wb_bits, 64'h0);
    chk("after_reset_done_cycles", done_bits, 64'h0);
    chk("after_reset_ready_cycles", rdy_bits, 64'h3E);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
